// File: rtl/ila_readout.sv
// ---------------------------------------------------------------------------
// ila_readout
//
// Sequential dump engine for the ILA core's software-side sample buffer.
// A start pulse latches the sample count. The engine then walks every buffer
// index and, for each index, every DATA_W-wide slice of the sample. For each
// slice it presents index/value_select to the core, waits the fixed read
// latency, captures value, and offers the word on a valid/ready stream.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   start         one-cycle pulse, begins a dump (ignored while busy)
//   abort         terminates the dump in progress (no effect when idle)
//   samples       number of valid samples reported by the ILA core
//   index         buffer read address to the ILA core
//   value_select  slice select to the ILA core
//   value         slice read back from the ILA core, RD_LAT cycles later
//   o_data        stream word
//   o_valid       stream word valid
//   o_ready       consumer accepts the word
//   o_last        marks the final word of a dump
//   busy          dump in progress
//   done          one-cycle pulse on normal completion
//   words_sent    words accepted in the current or last dump
// ---------------------------------------------------------------------------
module ila_readout #(
    parameter int DATA_W   = 32,
    parameter int SIGNAL_W = 32,
    parameter int BUFFER_W = 10,
    parameter int SEL_W    = (((SIGNAL_W + DATA_W - 1) / DATA_W) == 1) ? 1
                             : $clog2((SIGNAL_W + DATA_W - 1) / DATA_W),
    parameter int RD_LAT   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [BUFFER_W-1:0] samples,
    output logic [BUFFER_W-1:0] index,
    output logic [SEL_W-1:0]    value_select,
    input  logic [DATA_W-1:0]   value,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_valid,
    input  logic                o_ready,
    output logic                o_last,
    output logic                busy,
    output logic                done,
    output logic [31:0]         words_sent
);

    localparam int NPARTS = (SIGNAL_W + DATA_W - 1) / DATA_W;
    // The wait counter only has to hold RD_LAT-1.
    localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [SEL_W-1:0]    LAST_SEL = SEL_W'(NPARTS - 1);
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [BUFFER_W-1:0] IDX_ONE  = BUFFER_W'(1);
    localparam logic [SEL_W-1:0]    SEL_ONE  = SEL_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ADDR,
        WAIT,
        SEND,
        FIN
    } state_t;

    state_t              state_q, state_d;
    logic [BUFFER_W-1:0] index_q, index_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   o_data_q, o_data_d;
    logic                o_valid_q, o_valid_d;
    logic                o_last_q, o_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [31:0]         words_sent_q, words_sent_d;
    logic [BUFFER_W-1:0] n_q, n_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        sel_d        = sel_q;
        o_data_d     = o_data_q;
        o_valid_d    = o_valid_q;
        o_last_d     = o_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        words_sent_d = words_sent_q;
        n_d          = n_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d          = samples;
                    words_sent_d = '0;
                    busy_d       = 1'b1;
                    state_d      = SETUP;
                end
            end

            SETUP: begin
                if (n_q == '0) begin
                    state_d = FIN;
                end else begin
                    index_d = '0;
                    sel_d   = '0;
                    state_d = ADDR;
                end
            end

            // index/value_select were settled on the way in; the read
            // latency is counted from here.
            ADDR: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end

            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    o_data_d  = value;
                    o_valid_d = 1'b1;
                    o_last_d  = (index_q == (n_q - IDX_ONE)) && (sel_q == LAST_SEL);
                    state_d   = SEND;
                end
            end

            // The word stays put until accepted; o_valid never looks at o_ready.
            SEND: begin
                if (o_ready) begin
                    words_sent_d = words_sent_q + 32'd1;
                    o_valid_d    = 1'b0;
                    if (o_last_q) begin
                        state_d = FIN;
                    end else if (sel_q != LAST_SEL) begin
                        sel_d   = sel_q + SEL_ONE;
                        state_d = ADDR;
                    end else begin
                        sel_d   = '0;
                        index_d = index_q + IDX_ONE;
                        state_d = ADDR;
                    end
                end
            end

            // index/value_select keep their last values after the dump.
            FIN: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                o_last_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything except a handshake already counted above.
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
            done_d    = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Control and visible-output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            index_q      <= '0;
            sel_q        <= '0;
            o_data_q     <= '0;
            o_valid_q    <= 1'b0;
            o_last_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            sel_q        <= sel_d;
            o_data_q     <= o_data_d;
            o_valid_q    <= o_valid_d;
            o_last_q     <= o_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            words_sent_q <= words_sent_d;
        end
    end

    // Latched count and wait counter are always written before use.
    always_ff @(posedge clk) begin
        n_q   <= n_d;
        cnt_q <= cnt_d;
    end

    assign index        = index_q;
    assign value_select = sel_q;
    assign o_data       = o_data_q;
    assign o_valid      = o_valid_q;
    assign o_last       = o_last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign words_sent   = words_sent_q;

endmodule

// File: tb/tb_ila_readout.sv
// ---------------------------------------------------------------------------
// tb_ila_readout
//
// Two engines: instance 0 with a 32-bit signal (one word per sample) and
// instance 1 with a 64-bit signal (two words per sample). Both read a shared
// behavioural sample buffer through a two-register read path. Only one engine
// is started at a time; expected words go into a scoreboard queue and a
// monitor pops and compares on every handshake.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ila_readout;

    localparam int DATA_W   = 32;
    localparam int BUFFER_W = 10;
    localparam int SEL_W    = 1;
    localparam int NDUT     = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                abort;
    logic                o_ready;
    logic [BUFFER_W-1:0] samples;
    logic                start        [NDUT];
    logic [BUFFER_W-1:0] index        [NDUT];
    logic [SEL_W-1:0]    value_select [NDUT];
    logic [DATA_W-1:0]   o_data       [NDUT];
    logic                o_valid      [NDUT];
    logic                o_last       [NDUT];
    logic                busy         [NDUT];
    logic                done         [NDUT];
    logic [31:0]         words_sent   [NDUT];

    logic [63:0] mem [1 << BUFFER_W];

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;
    exp_t exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    int hs_total   [NDUT] = '{0, 0};
    int done_total [NDUT] = '{0, 0};
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stall word 2 of DUT1, 3: never
    int stall_base = 0;
    int stall_cnt  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [DATA_W-1:0] ram_q;
        logic [DATA_W-1:0] value_q;

        ila_readout #(
            .DATA_W   (DATA_W),
            .SIGNAL_W ((g == 0) ? 32 : 64),
            .BUFFER_W (BUFFER_W),
            .RD_LAT   (2)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start[g]),
            .abort        (abort),
            .samples      (samples),
            .index        (index[g]),
            .value_select (value_select[g]),
            .value        (value_q),
            .o_data       (o_data[g]),
            .o_valid      (o_valid[g]),
            .o_ready      (o_ready),
            .o_last       (o_last[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .words_sent   (words_sent[g])
        );

        // ILA read path: RAM output register, then value register.
        always @(posedge clk) begin
            if (g == 0)
                ram_q <= (value_select[g] == '0) ? mem[index[g]][31:0] : 32'hDEAD_BEEF;
            else
                ram_q <= value_select[g][0] ? mem[index[g]][63:32] : mem[index[g]][31:0];
            value_q <= ram_q;
        end
    end

    function automatic void check(input string name, input longint unsigned act,
                                  input longint unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Expected stream: every slice of every sample, low slice first.
    function automatic void push_expect(input int d, input int n);
        int np = (d == 0) ? 1 : 2;
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < np; p++) begin
                exp_t e;
                e.data = (p == 0) ? mem[i][31:0] : mem[i][63:32];
                e.last = (i == n - 1) && (p == np - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    // -----------------------------------------------------------------------
    // Monitor: scoreboard pops on handshakes, hold checks while stalled.
    // -----------------------------------------------------------------------
    logic        prev_hold [NDUT] = '{1'b0, 1'b0};
    logic [31:0] prev_data [NDUT];
    logic        prev_last [NDUT];

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (done[d]) done_total[d]++;
            if (!rst) begin
                if (prev_hold[d]) begin
                    check("hold_valid", o_valid[d], 1);
                    check("hold_data", o_data[d], prev_data[d]);
                    check("hold_last", o_last[d], prev_last[d]);
                end
                if (o_valid[d] && o_ready) begin
                    hs_total[d]++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", o_data[d], 0);
                        n_fail += (o_data[d] == 0) ? 1 : 0;
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", o_data[d], e.data);
                        check("word_last", o_last[d], e.last);
                    end
                end
            end
            prev_hold[d] = o_valid[d] && !o_ready && !abort && !rst;
            prev_data[d] = o_data[d];
            prev_last[d] = o_last[d];
        end
    end

    // -----------------------------------------------------------------------
    // Consumer ready driver
    // -----------------------------------------------------------------------
    initial begin
        o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode != 2) stall_cnt = 0;
            case (ready_mode)
                0: o_ready = 1'b1;
                1: o_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (o_valid[1] && (hs_total[1] - stall_base == 1) && stall_cnt < 5) begin
                        o_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        o_ready = 1'b1;
                    end
                end
                default: o_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller in the first cycle after start was sampled.
    task automatic start_dump(input int d, input int n);
        samples  = BUFFER_W'(n);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        samples  = BUFFER_W'($urandom);   // must be ignored once latched
    endtask

    task automatic wait_done(input int d, input int budget, inout int cyc);
        while (!done[d] && cyc < budget) begin
            tick();
            cyc++;
        end
        check("done_seen", done[d], 1);
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_index", index[d], 0);
        check("rst_value_select", value_select[d], 0);
        check("rst_o_data", o_data[d], 0);
        check("rst_o_valid", o_valid[d], 0);
        check("rst_o_last", o_last[d], 0);
        check("rst_busy", busy[d], 0);
        check("rst_done", done[d], 0);
        check("rst_words_sent", words_sent[d], 0);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int cyc, base, dbase, d, n, np;
        bit do_abort;

        rst = 1'b1; abort = 1'b0; samples = '0;
        start[0] = 1'b0; start[1] = 1'b0;
        for (int i = 0; i < (1 << BUFFER_W); i++) mem[i] = '0;
        repeat (3) tick();
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst = 1'b0;
        tick();

        // Four 32-bit samples, ready tied high: 4 words take 4*4+3 cycles.
        for (int i = 0; i < 4; i++) mem[i] = {32'($urandom), 32'hA0 + 32'(i)};
        push_expect(0, 4);
        base = hs_total[0]; dbase = done_total[0];
        start_dump(0, 4);
        check("t1_busy", busy[0], 1);
        cyc = 1;
        wait_done(0, 100, cyc);
        check("t1_latency", cyc, 19);
        check("t1_busy_end", busy[0], 0);
        check("t1_words_sent", words_sent[0], 4);
        check("t1_accepted", hs_total[0] - base, 4);
        tick();
        check("t1_done_one_cycle", done[0], 0);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_done_count", done_total[0] - dbase, 1);

        // Two 64-bit samples split into low then high word.
        mem[0] = 64'h11112222_33334444;
        mem[1] = 64'h55556666_77778888;
        push_expect(1, 2);
        start_dump(1, 2);
        cyc = 1;
        wait_done(1, 100, cyc);
        check("t2_latency", cyc, 19);
        check("t2_words_sent", words_sent[1], 4);
        tick();
        check("t2_queue_empty", exp_q.size(), 0);

        // Empty buffer: no words, done right after setup.
        base = hs_total[0];
        start_dump(0, 0);
        cyc = 1;
        wait_done(0, 50, cyc);
        check("t3_latency", cyc, 3);
        check("t3_words_sent", words_sent[0], 0);
        check("t3_accepted", hs_total[0] - base, 0);
        tick();

        // Consumer stalls five cycles on the second word.
        for (int i = 0; i < 3; i++) mem[i] = {32'($urandom), 32'($urandom)};
        push_expect(1, 3);
        stall_base = hs_total[1];
        ready_mode = 2;
        start_dump(1, 3);
        cyc = 1;
        wait_done(1, 200, cyc);
        check("t4_stall_cycles", stall_cnt, 5);
        ready_mode = 0;
        check("t4_words_sent", words_sent[1], 6);
        tick();
        check("t4_queue_empty", exp_q.size(), 0);

        // Abort during the read wait of word 3, then a full restart.
        for (int i = 0; i < 8; i++) mem[i] = {32'($urandom), 32'($urandom)};
        push_expect(0, 8);
        base = hs_total[0]; dbase = done_total[0];
        start_dump(0, 8);
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy", busy[0], 0);
        check("t5_valid", o_valid[0], 0);
        check("t5_words_sent", words_sent[0], 2);
        check("t5_accepted", hs_total[0] - base, 2);
        check("t5_queue_left", exp_q.size(), 6);
        exp_q.delete();
        repeat (20) tick();
        check("t5_no_done", done_total[0] - dbase, 0);
        push_expect(0, 8);
        start_dump(0, 8);
        cyc = 1;
        wait_done(0, 200, cyc);
        check("t5_restart_latency", cyc, 35);
        check("t5_restart_words", words_sent[0], 8);
        tick();
        check("t5_queue_empty", exp_q.size(), 0);

        // Abort while idle changes nothing.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_idle_abort_words", words_sent[0], 8);
        check("t6_idle_abort_busy", busy[0], 0);

        // start+abort together in idle: start wins; a second start mid-dump is ignored.
        mem[0] = {32'($urandom), 32'($urandom)};
        mem[1] = {32'($urandom), 32'($urandom)};
        push_expect(1, 2);
        dbase = done_total[1];
        samples = BUFFER_W'(2);
        start[1] = 1'b1; abort = 1'b1;
        tick();
        start[1] = 1'b0; abort = 1'b0;
        check("t6_start_wins", busy[1], 1);
        cyc = 1;
        repeat (6) begin tick(); cyc++; end
        samples = BUFFER_W'(5);
        start[1] = 1'b1;
        tick(); cyc++;
        start[1] = 1'b0;
        wait_done(1, 100, cyc);
        check("t6_latency", cyc, 19);
        check("t6_words_sent", words_sent[1], 4);
        tick();
        check("t6_done_count", done_total[1] - dbase, 1);
        check("t6_queue_empty", exp_q.size(), 0);

        // Reset while a word waits for the consumer.
        for (int i = 0; i < 3; i++) mem[i] = {32'($urandom), 32'($urandom)};
        push_expect(0, 3);
        ready_mode = 3;
        dbase = done_total[0];
        start_dump(0, 3);
        cyc = 1;
        while (!o_valid[0] && cyc < 30) begin tick(); cyc++; end
        check("t7_reached_send", o_valid[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs(0);
        exp_q.delete();
        ready_mode = 0;
        repeat (5) tick();
        check("t7_no_done", done_total[0] - dbase, 0);
        push_expect(0, 3);
        start_dump(0, 3);
        cyc = 1;
        wait_done(0, 100, cyc);
        check("t7_fresh_latency", cyc, 15);
        check("t7_fresh_words", words_sent[0], 3);
        tick();
        check("t7_queue_empty", exp_q.size(), 0);

        // Randomised dumps with random backpressure and occasional aborts.
        ready_mode = 1;
        for (int it = 0; it < 40; it++) begin
            d  = $urandom_range(0, 1);
            n  = $urandom_range(0, 6);
            np = (d == 0) ? 1 : 2;
            do_abort = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) mem[i] = {32'($urandom), 32'($urandom)};
            push_expect(d, n);
            base = hs_total[d]; dbase = done_total[d];
            start_dump(d, n);
            if (do_abort) begin
                repeat ($urandom_range(0, 30)) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("rnd_abort_busy", busy[d], 0);
                check("rnd_abort_valid", o_valid[d], 0);
                check("rnd_abort_words", words_sent[d], hs_total[d] - base);
                exp_q.delete();
            end else begin
                cyc = 1;
                wait_done(d, 500, cyc);
                check("rnd_words_sent", words_sent[d], n * np);
                tick();
                check("rnd_queue_empty", exp_q.size(), 0);
                check("rnd_done_count", done_total[d] - dbase, 1);
            end
            repeat (2) tick();
        end
        ready_mode = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
